// File: rtl/cla_add_pipe_16b_pkg.sv
// Shared widths and the 4-bit carry-lookahead cell used by the pipelined adder.
package cla_add_pipe_16b_pkg;

    localparam int ADD_W  = 16;
    localparam int HALF_W = 8;

    typedef struct packed {
        logic [3:0] sum;
        logic       grpP;
        logic       grpG;
    } cla4_t;

    // Carries come from flattened lookahead terms, so no carry ripples inside a cell.
    function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        cla4_t      r;
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        r.sum  = p ^ c;
        r.grpP = &p;
        r.grpG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_add_pipe_16b_if.sv
// Operand/result handshake bundle between operand select, the adder and the result mux.
interface cla_add_pipe_16b_if
    import cla_add_pipe_16b_pkg::*;
#(
    parameter int N = ADD_W
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/cla_add_8b.sv
// 8-bit carry-lookahead adder: two 4-bit cells joined through their group P/G terms.
module cla_add_8b
    import cla_add_pipe_16b_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] sum_o,
    output logic       c_o
);

    cla4_t loCell;
    cla4_t hiCell;
    logic  midCarry;

    assign loCell   = cla4(a_i[3:0], b_i[3:0], c_i);
    assign midCarry = loCell.grpG | (loCell.grpP & c_i);
    assign hiCell   = cla4(a_i[7:4], b_i[7:4], midCarry);

    assign sum_o = {hiCell.sum, loCell.sum};
    assign c_o   = hiCell.grpG | (hiCell.grpP & loCell.grpG) | (hiCell.grpP & loCell.grpP & c_i);

endmodule

// File: rtl/cla_add_pipe_16b.sv
// Two-stage add/subtract: stage 1 resolves the low half, stage 2 the high half and flags.
module cla_add_pipe_16b
    import cla_add_pipe_16b_pkg::*;
#(
    parameter int N = ADD_W
)(
    input  logic              clk,
    input  logic              rst_n,
    cla_add_pipe_16b_if.slave bus
);

    localparam int H    = N / 2;
    localparam int SEGS = H / HALF_W;

    logic         en1;
    logic         en2;
    logic [N-1:0] bx;
    logic [SEGS:0] c1Chain;
    logic [SEGS:0] c2Chain;
    logic [H-1:0] loSum_d;
    logic [H-1:0] hiSum_d;
    logic [N-1:0] sum_d;
    logic         ovf_d;
    logic         zero_d;

    logic         v1_q;
    logic [H-1:0] loSum_q;
    logic         cMid_q;
    logic [H-1:0] aHi_q;
    logic [H-1:0] bxHi_q;

    logic         v2_q;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         zero_q;

    // Subtract is A + ~B + 1, with the +1 entering as the stage-1 carry-in.
    assign bx         = bus.sub ? ~bus.b : bus.b;
    assign c1Chain[0] = bus.sub;
    assign c2Chain[0] = cMid_q;

    for (genvar k = 0; k < SEGS; k++) begin : g_s1
        cla_add_8b u_add (
            .a_i   (bus.a[k*HALF_W +: HALF_W]),
            .b_i   (bx[k*HALF_W +: HALF_W]),
            .c_i   (c1Chain[k]),
            .sum_o (loSum_d[k*HALF_W +: HALF_W]),
            .c_o   (c1Chain[k+1])
        );
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_s2
        cla_add_8b u_add (
            .a_i   (aHi_q[k*HALF_W +: HALF_W]),
            .b_i   (bxHi_q[k*HALF_W +: HALF_W]),
            .c_i   (c2Chain[k]),
            .sum_o (hiSum_d[k*HALF_W +: HALF_W]),
            .c_o   (c2Chain[k+1])
        );
    end

    assign sum_d  = {hiSum_d, loSum_q};
    assign ovf_d  = (aHi_q[H-1] == bxHi_q[H-1]) && (hiSum_d[H-1] != aHi_q[H-1]);
    assign zero_d = ~|sum_d;

    assign en2 = !v2_q || bus.out_ready;
    assign en1 = !v1_q || en2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            loSum_q <= '0;
            cMid_q  <= 1'b0;
            aHi_q   <= '0;
            bxHi_q  <= '0;
        end else if (en1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                loSum_q <= loSum_d;
                cMid_q  <= c1Chain[SEGS];
                aHi_q   <= bus.a[N-1:H];
                bxHi_q  <= bx[N-1:H];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q  <= sum_d;
                cout_q <= c2Chain[SEGS];
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    // in_ready is the only output with a combinational path (from out_ready).
    assign bus.in_ready  = en1;
    assign bus.out_valid = v2_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
